// File: rtl/riscvboy_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO, sitting on the core data port.
// Software sees TXDATA, STATUS and BAUDDIV in a 16-byte window at BASE_ADDR.
module riscvboy_uart_tx #(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DEF_DIV    = 16'd433
) (
  input  logic        clk_sys,
  input  logic        rst_sys_n,
  input  logic        i_mem_wen,
  input  logic        i_mem_ren,
  input  logic [31:0] i_mem_addr,
  input  logic [31:0] i_mem_wdata,
  output logic [31:0] o_mem_rdata,
  output logic        o_uart_tx,
  output logic        o_irq_txempty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state, state_next;
  logic [15:0] cnt, cnt_next;
  logic [2:0]  bit_idx, bit_idx_next;
  logic [7:0]  shreg, shreg_next;
  logic        tx_next, irq_next, busy, pop;

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, level_raw;
  logic [6:0]  level;
  logic        full, empty, push, ovf;
  logic [15:0] div;

  logic        hit, wr_txdata, wr_status, wr_div;
  logic [1:0]  sel;
  logic [31:0] rd_val;
  logic        unused_bits;

  assign hit       = (i_mem_addr[31:4] == BASE_ADDR[31:4]);
  assign sel       = i_mem_addr[3:2];
  assign wr_txdata = hit && i_mem_wen && (sel == 2'd0);
  assign wr_status = hit && i_mem_wen && (sel == 2'd1);
  assign wr_div    = hit && i_mem_wen && (sel == 2'd2);
  assign unused_bits = &{1'b0, i_mem_addr[1:0], i_mem_wdata[31:16]};

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level_raw = wr_ptr - rd_ptr;
  assign level     = 7'(level_raw);
  assign push      = wr_txdata && !full;

  always_ff @(posedge clk_sys) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= i_mem_wdata[7:0];
    end
  end

  always_comb begin
    rd_val = 32'd0;
    if (hit) begin
      case (sel)
        2'd1:    rd_val = {21'd0, level, ovf, empty, full, busy};
        2'd2:    rd_val = {16'd0, div};
        default: rd_val = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ovf         <= 1'b0;
      div         <= DEF_DIV;
      o_mem_rdata <= 32'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (wr_txdata && full)
        ovf <= 1'b1;
      else if (wr_status && i_mem_wdata[3])
        ovf <= 1'b0;
      if (wr_div) div <= i_mem_wdata[15:0];
      // Read captures pre-write register contents.
      if (i_mem_ren) o_mem_rdata <= rd_val;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state         <= IDLE;
      cnt           <= 16'd0;
      bit_idx       <= 3'd0;
      shreg         <= 8'd0;
      o_uart_tx     <= 1'b1;
      o_irq_txempty <= 1'b1;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      bit_idx       <= bit_idx_next;
      shreg         <= shreg_next;
      o_uart_tx     <= tx_next;
      o_irq_txempty <= irq_next;
    end
  end

  // Each bit ends when the counter reaches 0; reload takes the live BAUDDIV.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    bit_idx_next = bit_idx;
    shreg_next   = shreg;
    pop          = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          shreg_next = mem[rd_ptr[AW-1:0]];
          cnt_next   = div;
          state_next = START;
        end
      end
      START: begin
        if (cnt == 16'd0) begin
          cnt_next     = div;
          bit_idx_next = 3'd0;
          state_next   = DATA;
        end else begin
          cnt_next = cnt - 16'd1;
        end
      end
      DATA: begin
        if (cnt == 16'd0) begin
          cnt_next = div;
          if (bit_idx == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
            shreg_next   = shreg >> 1;
          end
        end else begin
          cnt_next = cnt - 16'd1;
        end
      end
      STOP: begin
        if (cnt == 16'd0) begin
          if (!empty) begin
            pop        = 1'b1;
            shreg_next = mem[rd_ptr[AW-1:0]];
            cnt_next   = div;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt - 16'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Line level is computed for the upcoming state so the flop tracks the FSM.
  always_comb begin
    busy     = (state != IDLE);
    irq_next = empty && (state == IDLE);
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shreg_next[0];
      default: tx_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_riscvboy_uart_tx.sv
// Scoreboarded bench for riscvboy_uart_tx: a frame-level reference model predicts
// read data, popped frames and the idle/irq levels; monitors compare DUT outputs.
module tb_riscvboy_uart_tx;

  localparam logic [31:0] BASE    = 32'h1000_0000;
  localparam int          DEPTH   = 8;
  localparam logic [15:0] DEF_DIV = 16'd433;
  localparam logic [31:0] A_TX  = BASE;
  localparam logic [31:0] A_ST  = BASE + 32'h4;
  localparam logic [31:0] A_DIV = BASE + 32'h8;
  localparam logic [31:0] A_RSV = BASE + 32'hC;

  logic        clk_sys = 1'b0;
  logic        rst_sys_n = 1'b0;
  logic        i_mem_wen = 1'b0;
  logic        i_mem_ren = 1'b0;
  logic [31:0] i_mem_addr = 32'd0;
  logic [31:0] i_mem_wdata = 32'd0;
  logic [31:0] o_mem_rdata;
  logic        o_uart_tx;
  logic        o_irq_txempty;

  always #5 clk_sys = ~clk_sys;

  riscvboy_uart_tx #(
    .BASE_ADDR (BASE),
    .FIFO_DEPTH(DEPTH),
    .DEF_DIV   (DEF_DIV)
  ) dut (
    .clk_sys      (clk_sys),
    .rst_sys_n    (rst_sys_n),
    .i_mem_wen    (i_mem_wen),
    .i_mem_ren    (i_mem_ren),
    .i_mem_addr   (i_mem_addr),
    .i_mem_wdata  (i_mem_wdata),
    .o_mem_rdata  (o_mem_rdata),
    .o_uart_tx    (o_uart_tx),
    .o_irq_txempty(o_irq_txempty)
  );

  typedef struct {
    logic [7:0] b;
    int         div;
  } frame_t;

  frame_t      exp_frames[$];
  logic [31:0] rd_q[$];
  int          start_cyc[$];
  int          q_m[$];
  int          n_checks = 0;
  int          n_fail = 0;
  bit          m_busy = 1'b0;
  bit          m_ovf = 1'b0;
  bit          exp_irq = 1'b1;
  bit          rd_pend = 1'b0;
  bit          mon_en = 1'b1;
  bit          prev_tx = 1'b1;
  int          m_div = int'(DEF_DIV);
  int          m_end = 0;
  int          e = 0;
  int          frames_rx = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, got, expv, e);
    end
  endtask

  // Reference model: FIFO as a queue, serializer as "busy until frame end".
  task automatic model_step();
    logic       hit;
    logic [1:0] sel;
    bit         irq_pre, full_pre, pop;
    int         lvl, b;
    logic [31:0] rv;
    e++;
    hit      = (i_mem_addr[31:4] == BASE[31:4]);
    sel      = i_mem_addr[3:2];
    lvl      = q_m.size();
    irq_pre  = (lvl == 0) && !m_busy;
    full_pre = (lvl == DEPTH);
    if (i_mem_ren) begin
      rv = 32'd0;
      if (hit && sel == 2'd1)
        rv = 32'((m_busy ? 1 : 0) + (full_pre ? 2 : 0) + (lvl == 0 ? 4 : 0) +
                 (m_ovf ? 8 : 0) + 16 * lvl);
      else if (hit && sel == 2'd2)
        rv = 32'(m_div);
      rd_q.push_back(rv);
      rd_pend = 1'b1;
    end
    pop = 1'b0;
    if (!m_busy) begin
      pop = (lvl > 0);
    end else if (e == m_end) begin
      if (lvl > 0) pop = 1'b1;
      else m_busy = 1'b0;
    end
    if (pop) begin
      b      = q_m.pop_front();
      m_busy = 1'b1;
      m_end  = e + 10 * (m_div + 1);
      if (mon_en) exp_frames.push_back('{8'(b), m_div});
    end
    if (hit && i_mem_wen) begin
      case (sel)
        2'd0: if (full_pre) m_ovf = 1'b1; else q_m.push_back(int'(i_mem_wdata[7:0]));
        2'd1: if (i_mem_wdata[3]) m_ovf = 1'b0;
        2'd2: m_div = int'(i_mem_wdata[15:0]);
        default: ;
      endcase
    end
    exp_irq = irq_pre;
  endtask

  initial begin
    forever begin
      @(posedge clk_sys or negedge rst_sys_n);
      if (!rst_sys_n) begin
        q_m.delete();
        rd_q.delete();
        exp_frames.delete();
        m_busy  = 1'b0;
        m_ovf   = 1'b0;
        m_div   = int'(DEF_DIV);
        exp_irq = 1'b1;
        rd_pend = 1'b0;
      end else begin
        model_step();
      end
    end
  end

  // Read-data monitor: one cycle after a sampled read.
  initial begin
    forever begin
      @(negedge clk_sys);
      if (rd_pend) begin
        rd_pend = 1'b0;
        if (rd_q.size() == 0) chk("rdata_queue", 32'd0, 32'd1);
        else chk("rdata", o_mem_rdata, rd_q.pop_front());
      end
    end
  end

  // Level monitor: irq always, line high whenever the model says idle.
  initial begin
    forever begin
      @(negedge clk_sys);
      if (mon_en) begin
        chk("irq_txempty", 32'(o_irq_txempty), 32'(exp_irq));
        if (!m_busy) chk("tx_idle", 32'(o_uart_tx), 32'd1);
      end
    end
  end

  // Frame monitor: every cycle of a frame must carry the expected bit.
  initial begin
    frame_t     f;
    logic [9:0] pat;
    logic [7:0] got;
    bit         ok, abort;
    forever begin
      @(negedge clk_sys);
      if (mon_en && rst_sys_n && prev_tx && !o_uart_tx) begin
        frames_rx++;
        start_cyc.push_back(e);
        if (exp_frames.size() == 0) begin
          chk("frame_unexpected", 32'd1, 32'd0);
        end else begin
          f     = exp_frames.pop_front();
          pat   = {1'b1, f.b, 1'b0};
          ok    = 1'b1;
          abort = 1'b0;
          got   = 8'd0;
          for (int k = 0; k < 10 && !abort; k++) begin
            for (int c = 0; c <= f.div && !abort; c++) begin
              if (k > 0 || c > 0) @(negedge clk_sys);
              if (!rst_sys_n) abort = 1'b1;
              else begin
                if (o_uart_tx !== pat[k]) ok = 1'b0;
                if (c == 0 && k >= 1 && k <= 8) got[k-1] = o_uart_tx;
              end
            end
          end
          n_checks++;
          if (!ok || abort) begin
            n_fail++;
            $display("FAIL frame: got byte 0x%02h (shape_ok=%0d) expected byte 0x%02h div %0d",
                     got, ok, f.b, f.div);
          end
        end
      end
      prev_tx = o_uart_tx;
    end
  end

  task automatic cyc(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d);
    i_mem_wen   = w;
    i_mem_ren   = r;
    i_mem_addr  = a;
    i_mem_wdata = d;
    @(negedge clk_sys);
    i_mem_wen = 1'b0;
    i_mem_ren = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cyc(1'b1, 1'b0, a, d);
  endtask

  task automatic rd(input logic [31:0] a);
    cyc(1'b0, 1'b1, a, 32'd0);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((m_busy || q_m.size() > 0) && n < budget) begin
      @(negedge clk_sys);
      n++;
    end
    chk("idle_within_budget", 32'(n < budget), 32'd1);
    repeat (3) @(negedge clk_sys);
  endtask

  task automatic wait_low(input string name, input int budget);
    int n = 0;
    while (o_uart_tx === 1'b1 && n < budget) begin
      @(negedge clk_sys);
      n++;
    end
    chk(name, 32'(o_uart_tx), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fr0, s0;
    bit samp[30];
    int runs[4];
    int exp_runs[4];
    int r, sel;

    // Reset values
    repeat (3) @(negedge clk_sys);
    rst_sys_n = 1'b1;
    @(negedge clk_sys);
    chk("reset_tx", 32'(o_uart_tx), 32'd1);
    chk("reset_irq", 32'(o_irq_txempty), 32'd1);
    chk("reset_rdata", o_mem_rdata, 32'd0);
    rd(A_DIV);
    rd(A_ST);
    repeat (2) @(negedge clk_sys);

    // Single byte at DIV=3
    wr(A_DIV, 32'd3);
    wr(A_TX, 32'hA5);
    repeat (10) @(negedge clk_sys);
    rd(A_ST);
    wait_idle(200);
    chk("single_irq_after", 32'(o_irq_txempty), 32'd1);

    // Fill and overflow at DIV=0
    wr(A_DIV, 32'd0);
    fr0 = frames_rx;
    for (int i = 0; i < 10; i++) wr(A_TX, 32'($urandom_range(0, 255)));
    rd(A_ST);
    wr(A_ST, 32'h8);
    rd(A_ST);
    wait_idle(500);
    chk("fill_frame_count", 32'(frames_rx - fr0), 32'd9);

    // Back-to-back frames at DIV=1
    wr(A_DIV, 32'd1);
    s0 = start_cyc.size();
    wr(A_TX, 32'h00);
    wr(A_TX, 32'hFF);
    wait_idle(300);
    chk("b2b_frame_count", 32'(start_cyc.size() - s0), 32'd2);
    if (start_cyc.size() >= s0 + 2)
      chk("b2b_start_spacing", 32'(start_cyc[s0+1] - start_cyc[s0]), 32'd20);

    // Address decode and read-during-write
    wr(BASE + 32'h100, 32'h55);
    wr(A_RSV, 32'h77);
    rd(A_RSV);
    rd(BASE + 32'h20);
    cyc(1'b1, 1'b1, A_DIV, 32'd5);
    rd(A_DIV);
    rd(A_ST);
    repeat (30) @(negedge clk_sys);

    // BAUDDIV change in the middle of the start bit
    mon_en = 1'b0;
    wr(A_DIV, 32'd7);
    wr(A_TX, 32'h55);
    wait_low("divchg_start_seen", 40);
    samp[0] = o_uart_tx;
    wr(A_DIV, 32'd1);
    samp[1] = o_uart_tx;
    for (int i = 2; i < 30; i++) begin
      @(negedge clk_sys);
      samp[i] = o_uart_tx;
    end
    exp_runs = '{8, 2, 2, 2};
    runs = '{1, 0, 0, 0};
    r = 0;
    for (int i = 1; i < 30; i++) begin
      if (r < 4) begin
        if (samp[i] == samp[i-1]) runs[r]++;
        else begin
          r++;
          if (r < 4) runs[r] = 1;
        end
      end
    end
    for (int k = 0; k < 4; k++) chk($sformatf("divchg_run%0d", k), 32'(runs[k]), 32'(exp_runs[k]));
    rst_sys_n = 1'b0;
    @(negedge clk_sys);
    rst_sys_n = 1'b1;
    @(negedge clk_sys);

    // Asynchronous reset during DATA bit 3
    wr(A_DIV, 32'd3);
    wr(A_TX, 32'h00);
    wait_low("rstmid_start_seen", 40);
    repeat (17) @(negedge clk_sys);
    chk("rstmid_line_low_before", 32'(o_uart_tx), 32'd0);
    #1 rst_sys_n = 1'b0;
    #1;
    chk("rstmid_tx_async", 32'(o_uart_tx), 32'd1);
    chk("rstmid_irq_async", 32'(o_irq_txempty), 32'd1);
    @(negedge clk_sys);
    rst_sys_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk_sys);
    rd(A_ST);
    repeat (60) @(negedge clk_sys);

    // Randomized traffic
    wr(A_DIV, 32'($urandom_range(0, 2)));
    for (int i = 0; i < 80; i++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 3) wr(A_TX, 32'($urandom_range(0, 255)));
      else if (sel <= 5) rd(BASE + 32'(4 * $urandom_range(0, 3)));
      else if (sel == 6) wr(A_ST, 32'($urandom_range(0, 1) * 8));
      else repeat ($urandom_range(1, 8)) @(negedge clk_sys);
    end
    wait_idle(3000);
    rd(A_ST);
    repeat (3) @(negedge clk_sys);
    chk("frames_left", 32'(exp_frames.size()), 32'd0);
    chk("reads_left", 32'(rd_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
